count_monitor: RTL and testbench

Passive checker that sits directly downstream of the 4-bit up/down counter. It observes the counter's output together with the counter's own `dir` and `rstn` inputs. Every cycle it predicts the next count and flags any step that does not match. It also reports wrap-around events and threshold hits, so the bench gets pulses to synchronise on instead of polling the count.

---
 rtl/count_monitor.sv | 154 +++++++++++++++
 tb/tb_count_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Passive step checker for a W-bit up/down counter. It predicts each count from the previous
// sample and flags mismatches. It also reports wrap-around and threshold hits as registered pulses.
module count_monitor #(
  parameter int unsigned W   = 4,
  parameter int unsigned ECW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic [W-1:0]   obs_cnt,
  input  logic           obs_dir,
  input  logic           obs_rstn,
  input  logic [W-1:0]   thresh,
  input  logic           clr_err,
  output logic           thr_hit,
  output logic           wrap_up,
  output logic           wrap_dn,
  output logic           err,
  output logic           err_sticky,
  output logic [ECW-1:0] err_cnt,
  output logic [1:0]     state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StTrack = 2'd2
  } state_e;

  localparam logic [W-1:0]   CntMax = '1;
  localparam logic [ECW-1:0] ErrMax = '1;

  state_e         state_q, state_d;
  logic [W-1:0]   prev_cnt_q, prev_cnt_d;
  logic           prev_dir_q, prev_dir_d;
  logic           prev_rst_q, prev_rst_d;
  logic           thr_hit_q, thr_hit_d;
  logic           wrap_up_q, wrap_up_d;
  logic           wrap_dn_q, wrap_dn_d;
  logic           err_q, err_d;
  logic           err_sticky_q, err_sticky_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  logic [W-1:0]   exp_cnt;
  logic           tracking;
  logic           sampling;
  logic           mismatch;

  always_comb begin
    state_d      = StIdle;
    prev_cnt_d   = prev_cnt_q;
    prev_dir_d   = prev_dir_q;
    prev_rst_d   = prev_rst_q;
    exp_cnt      = '0;
    tracking     = 1'b0;
    sampling     = 1'b0;
    mismatch     = 1'b0;
    thr_hit_d    = 1'b0;
    wrap_up_d    = 1'b0;
    wrap_dn_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      StIdle: begin
        state_d = en ? StPrime : StIdle;
      end
      StPrime: begin
        sampling = 1'b1;
        state_d  = en ? StTrack : StIdle;
      end
      StTrack: begin
        sampling = 1'b1;
        tracking = 1'b1;
        state_d  = en ? StTrack : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The previous sample is the exact cause of the current count.
    if (!prev_rst_q) begin
      exp_cnt = '0;
    end else if (prev_dir_q) begin
      exp_cnt = prev_cnt_q + W'(1);
    end else begin
      exp_cnt = prev_cnt_q - W'(1);
    end

    if (sampling) begin
      prev_cnt_d = obs_cnt;
      prev_dir_d = obs_dir;
      prev_rst_d = obs_rstn;
      thr_hit_d  = (obs_cnt == thresh);
    end

    if (tracking) begin
      mismatch  = (obs_cnt != exp_cnt);
      wrap_up_d = prev_rst_q && prev_dir_q && (prev_cnt_q == CntMax) && (obs_cnt == '0);
      wrap_dn_d = prev_rst_q && !prev_dir_q && (prev_cnt_q == '0) && (obs_cnt == CntMax);
    end

    // A mismatch on the clearing edge wins and counts as the first new error.
    if (mismatch) begin
      err_sticky_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = ECW'(1);
      end else if (err_cnt_q != ErrMax) begin
        err_cnt_d = err_cnt_q + ECW'(1);
      end
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end

    err_d = mismatch;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      prev_cnt_q   <= '0;
      prev_dir_q   <= 1'b0;
      prev_rst_q   <= 1'b0;
      thr_hit_q    <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_cnt_q   <= prev_cnt_d;
      prev_dir_q   <= prev_dir_d;
      prev_rst_q   <= prev_rst_d;
      thr_hit_q    <= thr_hit_d;
      wrap_up_q    <= wrap_up_d;
      wrap_dn_q    <= wrap_dn_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign thr_hit    = thr_hit_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_dn    = wrap_dn_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: a behavioural 4-bit counter drives two monitors (ECW 8 and 2),
// and a streak-based reference model predicts every output after every edge.
module tb_count_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, en, odir, orstn, clr;
  logic [3:0] obs, thresh;

  logic       a_thr, a_wup, a_wdn, a_err, a_sticky;
  logic [7:0] a_ecnt;
  logic [1:0] a_state;
  logic       b_thr, b_wup, b_wdn, b_err, b_sticky;
  logic [1:0] b_ecnt;
  logic [1:0] b_state;

  count_monitor #(.W(4), .ECW(8)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .obs_cnt(obs), .obs_dir(odir), .obs_rstn(orstn),
    .thresh(thresh), .clr_err(clr), .thr_hit(a_thr), .wrap_up(a_wup), .wrap_dn(a_wdn),
    .err(a_err), .err_sticky(a_sticky), .err_cnt(a_ecnt), .state(a_state)
  );

  count_monitor #(.W(4), .ECW(2)) dut_b (
    .clk(clk), .rstn(rstn), .en(en), .obs_cnt(obs), .obs_dir(odir), .obs_rstn(orstn),
    .thresh(thresh), .clr_err(clr), .thr_hit(b_thr), .wrap_up(b_wup), .wrap_dn(b_wdn),
    .err(b_err), .err_sticky(b_sticky), .err_cnt(b_ecnt), .state(b_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: monitor state is the length of the enabled streak, capped at 2.
  int streak = 0;
  int p_cnt = 0, p_dir = 0, p_rst = 0;
  int m_sticky = 0, m_ecnt = 0, m_ecnt2 = 0;
  int cnt = 0;
  int n_thr = 0, n_wup = 0, n_wdn = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  // One clock edge: predict, sample, compare, then advance the counter (plus an optional fault).
  task automatic tick(input int off);
    int  e_state, e_thr, e_wup, e_wdn, e_err, expv;
    bit  track, act;
    track = (streak >= 2);
    act   = (streak >= 1);
    e_thr = 0; e_wup = 0; e_wdn = 0; e_err = 0;
    if (!rstn) begin
      m_sticky = 0; m_ecnt = 0; m_ecnt2 = 0; streak = 0; e_state = 0;
      p_cnt = 0; p_dir = 0; p_rst = 0;
    end else begin
      expv  = (p_rst == 0) ? 0 : (p_dir != 0) ? (p_cnt + 1) % 16 : (p_cnt + 15) % 16;
      e_err = (track && obs != expv) ? 1 : 0;
      e_wup = (track && p_rst == 1 && p_dir == 1 && p_cnt == 15 && obs == 0) ? 1 : 0;
      e_wdn = (track && p_rst == 1 && p_dir == 0 && p_cnt == 0 && obs == 15) ? 1 : 0;
      e_thr = (act && obs == thresh) ? 1 : 0;
      if (e_err == 1) begin
        m_sticky = 1;
        m_ecnt   = clr ? 1 : sat_inc(m_ecnt, 255);
        m_ecnt2  = clr ? 1 : sat_inc(m_ecnt2, 3);
      end else if (clr) begin
        m_sticky = 0; m_ecnt = 0; m_ecnt2 = 0;
      end
      if (act) begin
        p_cnt = obs; p_dir = odir; p_rst = orstn;
      end
      streak  = en ? ((streak >= 2) ? 2 : streak + 1) : 0;
      e_state = streak;
    end
    @(posedge clk);
    #1;
    check_eq("state", a_state, e_state);
    check_eq("thr_hit", a_thr, e_thr);
    check_eq("wrap_up", a_wup, e_wup);
    check_eq("wrap_dn", a_wdn, e_wdn);
    check_eq("err", a_err, e_err);
    check_eq("err_sticky", a_sticky, m_sticky);
    check_eq("err_cnt", a_ecnt, m_ecnt);
    check_eq("err_cnt_ecw2", b_ecnt, m_ecnt2);
    check_eq("err_ecw2", b_err, e_err);
    n_thr += a_thr; n_wup += a_wup; n_wdn += a_wdn; n_err += a_err;
    cnt = (orstn == 0) ? 0 : (odir == 1) ? (cnt + 1) % 16 : (cnt + 15) % 16;
    cnt = (cnt + off) % 16;
    obs = 4'(cnt);
  endtask

  task automatic clear_pulse_counts();
    n_thr = 0; n_wup = 0; n_wdn = 0; n_err = 0;
  endtask

  initial begin
    bit found;
    rstn = 1'b0; en = 1'b0; odir = 1'b1; orstn = 1'b0; clr = 1'b0;
    thresh = 4'hE; obs = 4'h0;
    repeat (2) tick(0);

    // Count up from a counter reset through the 15 -> 0 wrap.
    rstn = 1'b1; en = 1'b1;
    clear_pulse_counts();
    repeat (2) tick(0);
    orstn = 1'b1;
    repeat (18) tick(0);
    check_eq("up_thr_pulses", n_thr, 1);
    check_eq("up_wrap_pulses", n_wup, 1);
    check_eq("up_err_pulses", n_err, 0);

    // Count down from 2 through the 0 -> 15 wrap.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (obs == 4'd2) found = 1; else tick(0);
    end
    check_eq("reach_2", found, 1);
    odir = 1'b0;
    clear_pulse_counts();
    repeat (6) tick(0);
    check_eq("dn_wrap_pulses", n_wdn, 1);
    check_eq("dn_err_cnt", a_ecnt, 0);

    // Fault: 7 seen where 5 is expected, then a correct 7 -> 8 step.
    odir = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (obs == 4'd4) found = 1; else tick(0);
    end
    check_eq("reach_4", found, 1);
    tick(2);
    check_eq("fault_obs", obs, 7);
    tick(0);
    check_eq("fault_err", a_err, 1);
    check_eq("fault_sticky", a_sticky, 1);
    check_eq("fault_cnt", a_ecnt, 1);
    tick(0);
    check_eq("recover_err", a_err, 0);

    // Clear on the same edge as a mismatch, with err_cnt at 3.
    repeat (3) tick(5);
    check_eq("pre_clr_cnt", a_ecnt, 3);
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    check_eq("clr_vs_err_cnt", a_ecnt, 1);
    check_eq("clr_vs_err_sticky", a_sticky, 1);

    // Five more mismatches: the ECW = 2 instance saturates.
    repeat (5) tick(5);
    tick(0);
    check_eq("sat_cnt_ecw2", b_ecnt, 3);
    check_eq("nosat_cnt_ecw8", a_ecnt, 6);

    // Drop enable for 3 cycles while the counter keeps running.
    clear_pulse_counts();
    en = 1'b0;
    repeat (3) tick(0);
    check_eq("drop_state", a_state, 0);
    en = 1'b1;
    tick(0);
    check_eq("reen_prime", a_state, 1);
    tick(0);
    check_eq("reen_track", a_state, 2);
    repeat (4) tick(0);
    check_eq("reen_err_pulses", n_err, 0);
    check_eq("reen_cnt_kept", a_ecnt, 6);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rstn   = ($urandom % 60) != 0;
      en     = ($urandom % 12) != 0;
      orstn  = ($urandom % 10) != 0;
      odir   = $urandom % 2;
      clr    = ($urandom % 25) == 0;
      thresh = 4'($urandom % 16);
      tick((($urandom % 20) == 0) ? int'($urandom_range(1, 15)) : 0);
    end

    // Reset mid-TRACK with a sticky error pending.
    rstn = 1'b1; en = 1'b1; orstn = 1'b1; clr = 1'b0;
    repeat (3) tick(0);
    tick(3);
    tick(0);
    check_eq("pre_rst_sticky", a_sticky, 1);
    rstn = 1'b0;
    tick(0);
    check_eq("rst_state", a_state, 0);
    check_eq("rst_sticky", a_sticky, 0);
    check_eq("rst_cnt", a_ecnt, 0);
    check_eq("rst_thr", a_thr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
